ad_jesd_adc_unpack: RTL and testbench
=====================================

// Module: ad_jesd_adc_unpack
// PURPOSE
//  Generalised JESD204 ADC transport stage in the adc_clk domain: takes lane-beat data from the link layer and realigns frames on rx_sof.
//  Splits the stream into NUM_CHANNELS interleaved 16-bit sample containers, then formats, range-flags and enable-masks each container.
//  Buffers output in a small FIFO with a valid/ready handshake towards the DMA.
//  Sits between the JESD RX link layer and the ADC DMA, replacing fixed single-channel, no-backpressure unpacking.
// PARAMETERS
//  NUM_LANES     8   JESD lanes; beat width DW = NUM_LANES*32
//  NUM_CHANNELS  1   converters; containers per beat (DW/16) must divide evenly by NUM_CHANNELS
//  SAMPLE_WIDTH  12  valid MSBs per 16-bit container (8..16)
//  FIFO_DEPTH    4   output FIFO entries, power of 2, >=2
// PORTS
//  adc_clk         in   1             link/sample clock (line-rate/40)
//  adc_rstn        in   1             async active-low reset
//  rx_data         in   DW            lane beat, lane n at [32n+31:32n], octet 0 in MSB byte
//  rx_sof          in   4             one-hot start-of-frame octet position, common to all lanes
//  rx_valid        in   1             beat qualifier
//  rx_ready        out  1             constant 1; the link layer cannot stall
//  adc_enable      in   NUM_CHANNELS  per-channel enable; disabled channel containers are output as 0
//  adc_dfmt_enable in   1             1: apply format; 0: raw container passthrough
//  adc_dfmt_type   in   1             1: offset-binary input (invert sample MSB); 0: two's complement
//  adc_dfmt_se     in   1             1: sign-extend sample to 16 bits; 0: zero-fill
//  adc_data        out  DW            FIFO head, container k = channel k%NUM_CHANNELS
//  adc_valid       out  1             FIFO non-empty
//  adc_ready       in   1             DMA accept; a pop occurs when valid&ready
//  adc_or          out  NUM_CHANNELS  sticky over-range per channel
//  adc_or_clr      in   1             clears adc_or
//  adc_dovf        out  1             sticky overflow: beat dropped while FIFO full
//  adc_dovf_clr    in   1             clears adc_dovf
//  adc_align_err   out  1             sticky: rx_sof non-zero and not one-hot
//  adc_fifo_level  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy
// BEHAVIOUR
//  Reset: all outputs 0 except rx_ready=1; FIFO flushed; alignment offset=0; previous-beat register=0.
//  Reset mid-operation: in-flight beats are discarded; no partial beat appears after adc_rstn rises.
//  S1 input register: captures rx_data/rx_sof only when rx_valid; the stage valid bit follows rx_valid.
//  S2 align:
//    - One-hot rx_sof at octet p latches offset=p.
//    - Each lane output = 32 bits taken from {prev_lane,cur_lane} starting at octet p, i.e. frame-aligned across the beat boundary.
//    - rx_sof=0 keeps the offset.
//    - Multi-bit rx_sof keeps the old offset and sets adc_align_err.
//  S3 format: per container, s = c[15 -: SAMPLE_WIDTH].
//    - dfmt_type=1 inverts the MSB of s.
//    - Result is sign- or zero-extended to 16 bits.
//    - With adc_dfmt_enable=0 the container passes raw.
//    - Over-range when raw s is all-ones or all-zeros; sets adc_or[ch].
//    - Disabled channels are zeroed after the over-range check; their adc_or is still flagged.
//  Latency: rx_valid beat -> FIFO write after 3 adc_clk cycles; adc_valid asserts 1 cycle after a write into an empty FIFO (4 total).
//  FIFO, show-ahead:
//    - Write and read in the same cycle is legal at any level, including full (level unchanged).
//    - Write when full with no pop: beat dropped, adc_dovf set.
//    - Read when empty: ignored.
//  Pointers are log2(FIFO_DEPTH) bits and wrap at FIFO_DEPTH, with a separate level counter.
//  Sticky clear vs new event in the same cycle: the set wins (adc_or, adc_dovf, adc_align_err).
//    - adc_align_err clears only on reset.
//  Config inputs are quasi-static; a change takes effect on the next beat entering S3.
// STRUCTURE
//  Package ad_jesd_adc_pkg: CONTAINER_W=16, OCTETS_PER_LANE=4, and a function for the channel index of a container.
//  Sub-module ad_jesd_adc_fmt: one 16-bit container -> formatted sample + over-range bit; generate-instantiated DW/16 times in S3.
//  The FIFO is inline: a register array plus wr/rd pointers and a level counter.
// TESTING
//  1 Reset, then NUM_LANES=1, rx_sof=4'b0001, rx_data=0x1234ABCD, dfmt_enable=0, adc_ready=1
//    -> adc_data=0x1234ABCD, adc_valid asserted 4 cycles after the beat.
//  2 Beat A=0xAABBCCDD with rx_sof=4'b0100 (p=2), then beat B=0x11223344 with rx_sof=0
//    -> second output lane word=0xCCDD1122.
//  3 SAMPLE_WIDTH=12, type=1, se=1, container 0x8000 -> 0x0000; container 0xFFF0 -> 0x07FF with adc_or=1.
//    Then adc_or_clr pulsed together with a new 0x0000 container -> adc_or stays 1.
//  4 NUM_CHANNELS=2, adc_enable=2'b01, containers 0x1110,0x2220 -> 0x1110,0x0000.
//  5 FIFO_DEPTH=4, adc_ready=0, 6 consecutive beats -> level 4, adc_dovf=1, beats 5-6 lost.
//    Then adc_ready=1 -> beats 1-4 emitted in order; adc_dovf_clr -> 0.
//  6 rx_sof=4'b0011 -> adc_align_err=1, offset unchanged.
//    Assert adc_rstn low mid-stream -> all outputs 0, rx_ready=1, level 0.

Source files
------------

// File: rtl/ad_jesd_adc_pkg.sv
// ad_jesd_adc_pkg: shared constants and helpers for the JESD204 ADC
// transport stage.
package ad_jesd_adc_pkg;

  localparam int CONTAINER_W     = 16;
  localparam int OCTETS_PER_LANE = 4;
  localparam int LANE_W          = OCTETS_PER_LANE * 8;

  typedef logic [1:0] oct_t;

  function automatic int chan_of(input int k, input int nch);
    return k % nch;
  endfunction

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic oct_t oct_idx(input logic [3:0] v);
    oct_t r;
    case (v)
      4'b0010: r = 2'd1;
      4'b0100: r = 2'd2;
      4'b1000: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ad_jesd_adc_fmt.sv
// ad_jesd_adc_fmt: one 16-bit sample container to formatted sample,
// with over-range detect on the raw sample bits.
module ad_jesd_adc_fmt
  import ad_jesd_adc_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 12
) (
  input  logic [CONTAINER_W-1:0] i_c,
  input  logic                   i_en,
  input  logic                   i_dfmt_en,
  input  logic                   i_type,
  input  logic                   i_se,
  output logic [CONTAINER_W-1:0] o_d,
  output logic                   o_or
);

  localparam int SW = SAMPLE_WIDTH;

  logic [SW-1:0]          w_s;
  logic [SW-1:0]          w_t;
  logic [CONTAINER_W-1:0] w_ext;

  assign w_s = i_c[CONTAINER_W-1 -: SW];
  assign w_t = {w_s[SW-1] ^ i_type, w_s[SW-2:0]};

  if (SW < CONTAINER_W) begin : g_ext
    assign w_ext = {{(CONTAINER_W-SW){i_se & w_t[SW-1]}}, w_t};
  end else begin : g_full
    assign w_ext = w_t;
  end

  assign o_or = (&w_s) | ~(|w_s);

  // over-range is judged before masking so disabled channels still flag
  always_comb begin
    o_d = '0;
    if (i_en) begin
      o_d = i_dfmt_en ? w_ext : i_c;
    end
  end

endmodule

// File: rtl/ad_jesd_adc_unpack.sv
// ad_jesd_adc_unpack: JESD204 ADC transport stage - frame realign,
// per-channel formatting and an output FIFO towards the DMA.
module ad_jesd_adc_unpack
  import ad_jesd_adc_pkg::*;
#(
  parameter int NUM_LANES    = 8,
  parameter int NUM_CHANNELS = 1,
  parameter int SAMPLE_WIDTH = 12,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                             adc_clk,
  input  logic                             adc_rstn,
  input  logic [NUM_LANES*32-1:0]          rx_data,
  input  logic [3:0]                       rx_sof,
  input  logic                             rx_valid,
  output logic                             rx_ready,
  input  logic [NUM_CHANNELS-1:0]          adc_enable,
  input  logic                             adc_dfmt_enable,
  input  logic                             adc_dfmt_type,
  input  logic                             adc_dfmt_se,
  output logic [NUM_LANES*32-1:0]          adc_data,
  output logic                             adc_valid,
  input  logic                             adc_ready,
  output logic [NUM_CHANNELS-1:0]          adc_or,
  input  logic                             adc_or_clr,
  output logic                             adc_dovf,
  input  logic                             adc_dovf_clr,
  output logic                             adc_align_err,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  adc_fifo_level
);

  localparam int DW    = NUM_LANES * LANE_W;
  localparam int NCONT = DW / CONTAINER_W;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int LW    = $clog2(FIFO_DEPTH+1);

  // S1: input register
  logic          r_s1_v;
  logic [DW-1:0] r_s1_data;
  logic [3:0]    r_s1_sof;

  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      r_s1_v    <= 1'b0;
      r_s1_data <= '0;
      r_s1_sof  <= '0;
    end else begin
      r_s1_v <= rx_valid;
      if (rx_valid) begin
        r_s1_data <= rx_data;
        r_s1_sof  <= rx_sof;
      end
    end
  end

  // S2: frame alignment
  logic          w_sof_oh;
  logic          w_sof_bad;
  oct_t          w_off;
  logic [DW-1:0] w_aligned;
  oct_t          r_off;
  logic [DW-1:0] r_prev;
  logic          r_s2_v;
  logic [DW-1:0] r_s2_data;
  logic          r_align_err;

  assign w_sof_oh  = is_onehot4(r_s1_sof);
  assign w_sof_bad = (|r_s1_sof) & ~w_sof_oh;
  assign w_off     = w_sof_oh ? oct_idx(r_s1_sof) : r_off;

  // offset 0 is already frame aligned; others borrow from the prior beat
  always_comb begin
    w_aligned = '0;
    for (int n = 0; n < NUM_LANES; n++) begin
      case (w_off)
        2'd1: w_aligned[LANE_W*n +: LANE_W] =
                {r_prev[LANE_W*n +: 24], r_s1_data[LANE_W*n+24 +: 8]};
        2'd2: w_aligned[LANE_W*n +: LANE_W] =
                {r_prev[LANE_W*n +: 16], r_s1_data[LANE_W*n+16 +: 16]};
        2'd3: w_aligned[LANE_W*n +: LANE_W] =
                {r_prev[LANE_W*n +: 8], r_s1_data[LANE_W*n+8 +: 24]};
        default: w_aligned[LANE_W*n +: LANE_W] =
                r_s1_data[LANE_W*n +: LANE_W];
      endcase
    end
  end

  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      r_off       <= '0;
      r_prev      <= '0;
      r_s2_v      <= 1'b0;
      r_s2_data   <= '0;
      r_align_err <= 1'b0;
    end else begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_off     <= w_off;
        r_prev    <= r_s1_data;
        r_s2_data <= w_aligned;
        if (w_sof_bad) begin
          r_align_err <= 1'b1;
        end
      end
    end
  end

  // S3: per-container format
  logic [DW-1:0]           w_fmt;
  logic [NCONT-1:0]        w_cont_or;
  logic [NUM_CHANNELS-1:0] w_ch_or;
  logic                    r_s3_v;
  logic [DW-1:0]           r_s3_data;
  logic [NUM_CHANNELS-1:0] r_or;

  for (genvar k = 0; k < NCONT; k++) begin : g_fmt
    ad_jesd_adc_fmt #(
      .SAMPLE_WIDTH (SAMPLE_WIDTH)
    ) u_fmt (
      .i_c       (r_s2_data[CONTAINER_W*k +: CONTAINER_W]),
      .i_en      (adc_enable[chan_of(k, NUM_CHANNELS)]),
      .i_dfmt_en (adc_dfmt_enable),
      .i_type    (adc_dfmt_type),
      .i_se      (adc_dfmt_se),
      .o_d       (w_fmt[CONTAINER_W*k +: CONTAINER_W]),
      .o_or      (w_cont_or[k])
    );
  end

  always_comb begin
    w_ch_or = '0;
    for (int k = 0; k < NCONT; k++) begin
      w_ch_or[chan_of(k, NUM_CHANNELS)] =
        w_ch_or[chan_of(k, NUM_CHANNELS)] | w_cont_or[k];
    end
  end

  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      r_s3_v    <= 1'b0;
      r_s3_data <= '0;
      r_or      <= '0;
    end else begin
      r_s3_v <= r_s2_v;
      if (r_s2_v) begin
        r_s3_data <= w_fmt;
      end
      r_or <= (r_s2_v ? w_ch_or : '0) | (adc_or_clr ? '0 : r_or);
    end
  end

  // output FIFO, show-ahead
  logic [DW-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [LW-1:0] r_level;
  logic          r_dovf;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;

  assign w_full = (r_level == LW'(FIFO_DEPTH));
  assign w_pop  = (r_level != '0) & adc_ready;
  assign w_push = r_s3_v & (~w_full | w_pop);
  assign w_drop = r_s3_v & w_full & ~w_pop;

  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
      r_dovf  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= r_s3_data;
        r_wp        <= r_wp + PW'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      r_dovf <= w_drop | (adc_dovf_clr ? 1'b0 : r_dovf);
    end
  end

  assign rx_ready       = 1'b1;
  assign adc_valid      = (r_level != '0);
  assign adc_data       = adc_valid ? r_mem[r_rp] : '0;
  assign adc_or         = r_or;
  assign adc_dovf       = r_dovf;
  assign adc_align_err  = r_align_err;
  assign adc_fifo_level = r_level;

endmodule

// File: tb/tb_ad_jesd_adc_unpack.sv
// tb_ad_jesd_adc_unpack: directed and randomized checks of the ADC
// transport stage against a behavioural model.
module tb_ad_jesd_adc_unpack;

  localparam int NL  = 1;
  localparam int NCH = 2;
  localparam int SW  = 12;
  localparam int FD  = 4;
  localparam int DW  = NL * 32;

  logic          adc_clk;
  logic          adc_rstn;
  logic [DW-1:0] rx_data;
  logic [3:0]    rx_sof;
  logic          rx_valid;
  logic          rx_ready;
  logic [1:0]    adc_enable;
  logic          adc_dfmt_enable;
  logic          adc_dfmt_type;
  logic          adc_dfmt_se;
  logic [DW-1:0] adc_data;
  logic          adc_valid;
  logic          adc_ready;
  logic [1:0]    adc_or;
  logic          adc_or_clr;
  logic          adc_dovf;
  logic          adc_dovf_clr;
  logic          adc_align_err;
  logic [2:0]    adc_fifo_level;

  ad_jesd_adc_unpack #(
    .NUM_LANES    (NL),
    .NUM_CHANNELS (NCH),
    .SAMPLE_WIDTH (SW),
    .FIFO_DEPTH   (FD)
  ) dut (
    .adc_clk         (adc_clk),
    .adc_rstn        (adc_rstn),
    .rx_data         (rx_data),
    .rx_sof          (rx_sof),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .adc_enable      (adc_enable),
    .adc_dfmt_enable (adc_dfmt_enable),
    .adc_dfmt_type   (adc_dfmt_type),
    .adc_dfmt_se     (adc_dfmt_se),
    .adc_data        (adc_data),
    .adc_valid       (adc_valid),
    .adc_ready       (adc_ready),
    .adc_or          (adc_or),
    .adc_or_clr      (adc_or_clr),
    .adc_dovf        (adc_dovf),
    .adc_dovf_clr    (adc_dovf_clr),
    .adc_align_err   (adc_align_err),
    .adc_fifo_level  (adc_fifo_level)
  );

  initial begin
    adc_clk = 1'b0;
    forever #5 adc_clk = ~adc_clk;
  end

  typedef struct {
    logic [31:0] w;
    int          due;
  } pend_t;

  int          total = 0;
  int          bad   = 0;
  int          edge_n = 0;
  logic [31:0] m_prev;
  int          m_off;
  logic [1:0]  m_or;
  bit          m_dovf;
  bit          m_aerr;
  pend_t       pend[$];
  logic [31:0] fq[$];
  int          aerr_q[$];
  logic [31:0] seen[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_prev = '0;
    m_off  = 0;
    m_or   = '0;
    m_dovf = 0;
    m_aerr = 0;
    pend.delete();
    fq.delete();
    aerr_q.delete();
  endtask

  function automatic logic [31:0] align(input logic [31:0] prv,
                                        input logic [31:0] cur,
                                        input int p);
    logic [63:0] cat;
    int          s;
    cat = {prv, cur};
    s   = (p == 0) ? 4 : p;
    return 32'(cat >> (8 * (4 - s)));
  endfunction

  task automatic fmt(input logic [31:0] raw, output logic [31:0] o,
                     output logic [1:0] orm);
    int c;
    int s;
    int t;
    int ch;
    o   = '0;
    orm = '0;
    for (int k = 0; k < 2; k++) begin
      c  = int'(raw[16*k +: 16]);
      s  = c >> (16 - SW);
      ch = k % NCH;
      if (s == 0 || s == (1 << SW) - 1) orm[ch] = 1'b1;
      t = adc_dfmt_type ? (s ^ (1 << (SW - 1))) : s;
      if (adc_dfmt_se && t >= (1 << (SW - 1))) t = t - (1 << SW);
      if (!adc_enable[ch]) o[16*k +: 16] = 16'h0;
      else if (!adc_dfmt_enable) o[16*k +: 16] = c[15:0];
      else o[16*k +: 16] = t[15:0];
    end
  endtask

  task automatic compare_all();
    logic [31:0] head;
    head = '0;
    if (fq.size() > 0) head = fq[0];
    chk("rx_ready", rx_ready, 1);
    chk("valid", adc_valid, fq.size() > 0);
    chk("level", adc_fifo_level, fq.size());
    chk("data", adc_data, head);
    chk("or", adc_or, m_or);
    chk("dovf", adc_dovf, m_dovf);
    chk("align_err", adc_align_err, m_aerr);
  endtask

  // advance the model across the next rising edge, then compare
  task automatic step();
    int          e;
    bit          pop;
    bit          drop;
    logic [1:0]  orev;
    logic [1:0]  orm;
    logic [31:0] fw;
    int          p;
    e    = edge_n + 1;
    pop  = (fq.size() > 0) && adc_ready;
    drop = 0;
    orev = '0;
    if (pop) seen.push_back(adc_data);
    foreach (pend[i]) begin
      if (pend[i].due - 1 == e) begin
        fmt(pend[i].w, fw, orm);
        pend[i].w = fw;
        orev      = orev | orm;
      end
    end
    if (pop) void'(fq.pop_front());
    if (pend.size() > 0 && pend[0].due == e) begin
      if (fq.size() == FD) drop = 1;
      else fq.push_back(pend[0].w);
      void'(pend.pop_front());
    end
    m_or   = orev | (adc_or_clr ? 2'b00 : m_or);
    m_dovf = drop | (adc_dovf_clr ? 1'b0 : m_dovf);
    if (aerr_q.size() > 0 && aerr_q[0] == e) begin
      m_aerr = 1;
      void'(aerr_q.pop_front());
    end
    if (rx_valid) begin
      if ($countones(rx_sof) == 1) m_off = $clog2(rx_sof);
      if ($countones(rx_sof) > 1) aerr_q.push_back(e + 1);
      p = m_off;
      pend.push_back('{w: align(m_prev, rx_data, p), due: e + 3});
      m_prev = rx_data;
    end
    @(posedge adc_clk);
    edge_n = e;
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic beat(input logic [31:0] d, input logic [3:0] sof);
    rx_data  = d;
    rx_sof   = sof;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    rx_sof   = 4'b0;
  endtask

  task automatic do_reset();
    rx_valid     = 1'b0;
    rx_sof       = 4'b0;
    adc_or_clr   = 1'b0;
    adc_dovf_clr = 1'b0;
    adc_rstn     = 1'b0;
    #1;
    model_clear();
    compare_all();
    idle(2);
    adc_rstn = 1'b1;
  endtask

  initial begin
    adc_rstn        = 1'b1;
    rx_data         = '0;
    rx_sof          = 4'b0;
    rx_valid        = 1'b0;
    adc_enable      = 2'b11;
    adc_dfmt_enable = 1'b0;
    adc_dfmt_type   = 1'b0;
    adc_dfmt_se     = 1'b0;
    adc_ready       = 1'b1;
    adc_or_clr      = 1'b0;
    adc_dovf_clr    = 1'b0;
    model_clear();
    #1;
    do_reset();

    // aligned raw beat, 4-cycle latency to adc_valid
    beat(32'h1234ABCD, 4'b0001);
    idle(2);
    chk("lat3_valid", adc_valid, 0);
    step();
    chk("lat4_valid", adc_valid, 1);
    chk("lat4_data", adc_data, 32'h1234ABCD);
    idle(2);

    // frame start at octet 2 straddles beats
    beat(32'hAABBCCDD, 4'b0100);
    beat(32'h11223344, 4'b0000);
    idle(6);
    chk("align_a", seen[seen.size()-2], 32'hABCDAABB);
    chk("align_b", seen[seen.size()-1], 32'hCCDD1122);

    // offset-binary, sign-extended format and over-range
    adc_dfmt_enable = 1'b1;
    adc_dfmt_type   = 1'b1;
    adc_dfmt_se     = 1'b1;
    beat(32'hFFF08000, 4'b0001);
    idle(5);
    chk("fmt_word", seen[seen.size()-1], 32'h07FF0000);
    chk("fmt_or", adc_or, 2'b10);
    beat(32'h00001230, 4'b0000);
    step();
    adc_or_clr = 1'b1;
    step();
    adc_or_clr = 1'b0;
    chk("or_set_wins", adc_or, 2'b10);
    adc_or_clr = 1'b1;
    step();
    adc_or_clr = 1'b0;
    chk("or_cleared", adc_or, 2'b00);
    idle(4);
    chk("fmt_neg", seen[seen.size()-1], 32'hF800F923);

    // channel enable mask
    adc_dfmt_enable = 1'b0;
    adc_dfmt_type   = 1'b0;
    adc_dfmt_se     = 1'b0;
    adc_enable      = 2'b01;
    beat(32'h22201110, 4'b0000);
    idle(5);
    chk("mask", seen[seen.size()-1], 32'h00001110);
    adc_enable = 2'b11;

    // overflow with a stalled DMA
    adc_ready = 1'b0;
    for (int i = 0; i < 6; i++) beat(32'h11111111 * (i + 1), 4'b0000);
    idle(4);
    chk("ovf_level", adc_fifo_level, 4);
    chk("ovf_flag", adc_dovf, 1);
    adc_ready = 1'b1;
    idle(6);
    for (int i = 0; i < 4; i++)
      chk("ovf_order", seen[seen.size()-4+i], 32'h11111111 * (i + 1));
    adc_dovf_clr = 1'b1;
    step();
    adc_dovf_clr = 1'b0;
    chk("dovf_clr", adc_dovf, 0);

    // multi-bit sof keeps offset and sets the sticky error
    beat(32'h55667788, 4'b0100);
    beat(32'h99AABBCC, 4'b0011);
    idle(6);
    chk("aerr", adc_align_err, 1);
    chk("aerr_keep", seen[seen.size()-1], 32'h778899AA);

    // reset with beats in flight and queued
    adc_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(32'hC0DE0000 + i, 4'b0000);
    idle(2);
    do_reset();
    chk("rst_level", adc_fifo_level, 0);
    chk("rst_aerr", adc_align_err, 0);
    adc_ready = 1'b1;
    idle(8);
    chk("rst_empty", adc_valid, 0);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      int r;
      if (c % 25 == 0) begin
        adc_enable      = 2'($urandom_range(0, 3));
        adc_dfmt_enable = 1'($urandom_range(0, 1));
        adc_dfmt_type   = 1'($urandom_range(0, 1));
        adc_dfmt_se     = 1'($urandom_range(0, 1));
      end
      rx_valid = ($urandom_range(0, 2) != 0);
      rx_data  = $urandom;
      r        = $urandom_range(0, 31);
      if (r < 26) rx_sof = 4'b0;
      else if (r < 31) rx_sof = 4'b1 << $urandom_range(0, 3);
      else rx_sof = 4'b1010;
      if ((c / 60) % 2 == 1) adc_ready = ($urandom_range(0, 3) != 0);
      else adc_ready = ($urandom_range(0, 2) == 0);
      adc_or_clr   = ($urandom_range(0, 15) == 0);
      adc_dovf_clr = ($urandom_range(0, 15) == 0);
      step();
    end
    rx_valid     = 1'b0;
    rx_sof       = 4'b0;
    adc_or_clr   = 1'b0;
    adc_dovf_clr = 1'b0;
    adc_ready    = 1'b1;
    idle(10);
    chk("drained", adc_fifo_level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
